i2c_codec_responder: RTL and testbench

//  I2C target (responder) emulating the audio codec's 2-wire control port: decodes 3-byte

---
 rtl/i2c_codec_responder_if.sv | 9 +
 rtl/i2c_codec_responder.sv | 186 ++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_codec_responder_if.sv
// I2C line bundle between a bus master (or bench) and the codec responder.
interface i2c_codec_responder_if;
   logic scl_in;
   logic sda_in;
   logic sda_oe;

   modport master (output scl_in, output sda_in, input sda_oe);
   modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_codec_responder.sv
// I2C write-only codec control-port stand-in with a 9-bit register file.
// Optional read-back of the last committed register: define I2C_RESP_READ_EN.
module i2c_codec_responder #(
   parameter logic [6:0]  DEV_ADDR    = 7'h1A,
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   i2c_codec_responder_if.slave  bus,
   output logic                  wr_strobe,
   output logic [6:0]            wr_addr,
   output logic [8:0]            wr_data,
   input  logic [3:0]            rd_addr,
   output logic [8:0]            rd_data,
   output logic                  busy,
   output logic                  err
);
   localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_WAIT_STOP
`ifdef I2C_RESP_READ_EN
      , S_RD_BYTE, S_RD_ACK
`endif
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic       scl_s, sda_s, scl_d, sda_d;
   logic       scl_rise, scl_fall, start, stop;
   logic [3:0] bit_cnt;
   logic [7:0] shreg, byte1;
   logic [8:0] regs [NUM_REGS];
   logic       addr_ok, in_xfer, commit, sda_oe_d, err_d, busy_d;
   logic [6:0] commit_addr;
   logic [8:0] commit_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s    = scl_sync[SYNC_STAGES-1];
   assign sda_s    = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_d;
   assign scl_fall = ~scl_s & scl_d;
   assign start    = scl_s & scl_d & sda_d & ~sda_s;
   assign stop     = scl_s & scl_d & ~sda_d & sda_s;
   assign in_xfer  = state_q inside {S_DEV_ADDR, S_DEV_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2};

   assign commit_addr = byte1[7:1];
   assign commit_data = {byte1[0], shreg};

`ifdef I2C_RESP_READ_EN
   logic [7:0] tx, tx_d;
   logic       mack, rd_second;
   logic [8:0] cur_reg;
   assign addr_ok = (shreg[7:1] == DEV_ADDR);
   assign cur_reg = (32'(wr_addr) < NUM_REGS) ? regs[AW'(wr_addr)] : '0;
`else
   assign addr_ok = (shreg == {DEV_ADDR, 1'b0});
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = S_DEV_ADDR;
      end else if (stop) begin
         state_d = S_IDLE;
      end else if (scl_fall) begin
         case (state_q)
            S_DEV_ADDR: if (bit_cnt == 4'd8) state_d = addr_ok ? S_DEV_ACK : S_WAIT_STOP;
`ifdef I2C_RESP_READ_EN
            S_DEV_ACK:  state_d = shreg[0] ? S_RD_BYTE : S_BYTE1;
            S_RD_BYTE:  if (bit_cnt == 4'd8) state_d = S_RD_ACK;
            S_RD_ACK:   state_d = (mack && !rd_second) ? S_RD_BYTE : S_WAIT_STOP;
`else
            S_DEV_ACK:  state_d = S_BYTE1;
`endif
            S_BYTE1:    if (bit_cnt == 4'd8) state_d = S_ACK1;
            S_ACK1:     state_d = S_BYTE2;
            S_BYTE2:    if (bit_cnt == 4'd8) state_d = S_ACK2;
            S_ACK2:     state_d = S_WAIT_STOP;
            default:    state_d = state_q;
         endcase
      end
   end

   // Output decode yields next-cycle register values; sda_oe only moves on SCL falls.
   always_comb begin
      sda_oe_d = bus.sda_oe;
      commit   = 1'b0;
      err_d    = 1'b0;
      busy_d   = busy;
`ifdef I2C_RESP_READ_EN
      tx_d = {tx[6:0], 1'b0};
      if (state_q == S_DEV_ACK)     tx_d = {wr_addr, cur_reg[8]};
      else if (state_q == S_RD_ACK) tx_d = cur_reg[7:0];
`endif
      if (start || stop) begin
         sda_oe_d = 1'b0;
         busy_d   = start;
         err_d    = in_xfer;
      end else if (scl_fall) begin
         commit = (state_q == S_ACK2);
         case (state_d)
            S_DEV_ACK, S_ACK1, S_ACK2: sda_oe_d = (state_d != state_q);
`ifdef I2C_RESP_READ_EN
            S_RD_BYTE: sda_oe_d = ~tx_d[7];
`endif
            default:   sda_oe_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.sda_oe <= 1'b0;
         wr_strobe  <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
         bit_cnt    <= '0;
         shreg      <= '0;
         byte1      <= '0;
         regs       <= '{default: '0};
`ifdef I2C_RESP_READ_EN
         tx         <= '0;
         mack       <= 1'b0;
         rd_second  <= 1'b0;
`endif
      end else begin
         bus.sda_oe <= sda_oe_d;
         err        <= err_d;
         busy       <= busy_d;
         wr_strobe  <= commit;
         if (start || stop) begin
            bit_cnt <= '0;
         end else if (scl_rise && bit_cnt < 4'd8 &&
                      state_q inside {S_DEV_ADDR, S_BYTE1, S_BYTE2
`ifdef I2C_RESP_READ_EN
                                      , S_RD_BYTE
`endif
                                      }) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
         end else if (scl_fall && state_d != state_q) begin
            bit_cnt <= '0;
         end
         if (scl_fall && state_q == S_BYTE1 && state_d == S_ACK1) byte1 <= shreg;
         if (commit) begin
            wr_addr <= commit_addr;
            wr_data <= commit_data;
            if (commit_addr == 7'h0F)
               regs <= '{default: '0};
            else if (32'(commit_addr) < NUM_REGS)
               regs[AW'(commit_addr)] <= commit_data;
         end
`ifdef I2C_RESP_READ_EN
         if (start) rd_second <= 1'b0;
         if (scl_rise && state_q == S_RD_ACK) mack <= ~sda_s;
         if (scl_fall && state_q == S_RD_ACK) rd_second <= 1'b1;
         if (scl_fall && state_d == S_RD_BYTE) tx <= tx_d;
`endif
      end
   end

   assign rd_data = (32'(rd_addr) < NUM_REGS) ? regs[AW'(rd_addr)] : '0;
endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder; read path exercised when I2C_RESP_READ_EN is defined.
module tb_i2c_codec_responder;
   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [3:0] rd_addr = '0;
   logic       wr_strobe, busy, err;
   logic [6:0] wr_addr;
   logic [8:0] wr_data, rd_data;

   int errors = 0;
   int checks = 0;
   int strobe_cnt = 0;
   int err_cnt = 0;
   int oe_cnt = 0;

   i2c_codec_responder_if bus ();
   assign bus.scl_in = scl_m;
   assign bus.sda_in = sda_m & ~bus.sda_oe;

   i2c_codec_responder #(.DEV_ADDR(7'h1A), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe)  strobe_cnt++;
      if (err)        err_cnt++;
      if (bus.sda_oe) oe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic quarter();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; scl_m = 1'b1; quarter();
      sda_m = 1'b0; quarter();
      scl_m = 1'b0; quarter();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; quarter();
      scl_m = 1'b1; quarter();
      sda_m = 1'b1; quarter();
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    quarter();
      scl_m = 1'b1; quarter(); quarter();
      scl_m = 1'b0; quarter();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      sda_m = 1'b1; quarter();
      scl_m = 1'b1; quarter();
      ack = ~bus.sda_in;
      quarter();
      scl_m = 1'b0; quarter();
   endtask

   task automatic read_byte(input logic give_ack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; quarter();
         scl_m = 1'b1; quarter();
         b[i] = bus.sda_in;
         quarter();
         scl_m = 1'b0; quarter();
      end
      write_bit(~give_ack);
      sda_m = 1'b1;
   endtask

   task automatic check_reg(input string tag, input logic [3:0] a, input logic [8:0] exp);
      rd_addr = a;
      #1;
      check(tag, {23'd0, rd_data}, {23'd0, exp});
   endtask

   initial begin
      logic ack;
      logic [7:0] rb;
      int s0, e0, o0;

      repeat (4) @(negedge clk);
      check("rst_sda_oe", {31'd0, bus.sda_oe}, 0);
      check("rst_wr_strobe", {31'd0, wr_strobe}, 0);
      check("rst_wr_addr", {25'd0, wr_addr}, 0);
      check("rst_wr_data", {23'd0, wr_data}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_err", {31'd0, err}, 0);
      rst = 1'b1;
      quarter();

      // 1: plain write of 0x012 to reg 4
      s0 = strobe_cnt; e0 = err_cnt;
      i2c_start();
      check("t1_busy", {31'd0, busy}, 1);
      send_byte(8'h34, ack); check("t1_ack0", {31'd0, ack}, 1);
      send_byte(8'h08, ack); check("t1_ack1", {31'd0, ack}, 1);
      send_byte(8'h12, ack); check("t1_ack2", {31'd0, ack}, 1);
      check("t1_strobe", strobe_cnt - s0, 1);
      check("t1_wr_addr", {25'd0, wr_addr}, 32'h04);
      check("t1_wr_data", {23'd0, wr_data}, 32'h012);
      check("t1_sda_rel", {31'd0, bus.sda_oe}, 0);
      i2c_stop();
      check("t1_busy_end", {31'd0, busy}, 0);
      check("t1_err", err_cnt - e0, 0);
      check_reg("t1_reg4", 4'd4, 9'h012);

      // 2: wrong device address
      s0 = strobe_cnt; e0 = err_cnt; o0 = oe_cnt;
      i2c_start();
      send_byte(8'h36, ack); check("t2_ack0", {31'd0, ack}, 0);
      send_byte(8'h00, ack); check("t2_ack1", {31'd0, ack}, 0);
      send_byte(8'h00, ack);
      i2c_stop();
      check("t2_oe", oe_cnt - o0, 0);
      check("t2_strobe", strobe_cnt - s0, 0);
      check("t2_err", err_cnt - e0, 0);
      check("t2_busy", {31'd0, busy}, 0);

      // 3: STOP before the data byte
      s0 = strobe_cnt; e0 = err_cnt;
      i2c_start();
      send_byte(8'h34, ack);
      send_byte(8'h0C, ack); check("t3_ack1", {31'd0, ack}, 1);
      i2c_stop();
      check("t3_err_pulse", err_cnt - e0, 1);
      check("t3_strobe", strobe_cnt - s0, 0);
      check("t3_busy", {31'd0, busy}, 0);
      check("t3_sda_oe", {31'd0, bus.sda_oe}, 0);
      check_reg("t3_reg4", 4'd4, 9'h012);
      check_reg("t3_reg6", 4'd6, 9'h000);

      // 4: bit-8 data to reg 5, then codec reset register clears everything
      i2c_start();
      send_byte(8'h34, ack); send_byte(8'h0B, ack); send_byte(8'hF0, ack);
      i2c_stop();
      check_reg("t4_reg5", 4'd5, 9'h1F0);
      s0 = strobe_cnt;
      i2c_start();
      send_byte(8'h34, ack); send_byte(8'h1E, ack); send_byte(8'h00, ack);
      i2c_stop();
      check("t4_strobe", strobe_cnt - s0, 1);
      check("t4_wr_addr", {25'd0, wr_addr}, 32'h0F);
      check_reg("t4_reg4", 4'd4, 9'h000);
      check_reg("t4_reg5", 4'd5, 9'h000);

      // 5: asynchronous reset in the middle of BYTE2
      i2c_start();
      send_byte(8'h34, ack); send_byte(8'h06, ack); send_byte(8'h55, ack);
      i2c_stop();
      check_reg("t5_reg3_pre", 4'd3, 9'h055);
      i2c_start();
      send_byte(8'h34, ack); send_byte(8'h08, ack);
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      check("t5_busy_pre", {31'd0, busy}, 1);
      rst = 1'b0;
      #1;
      check("t5_busy", {31'd0, busy}, 0);
      check("t5_sda_oe", {31'd0, bus.sda_oe}, 0);
      check_reg("t5_reg3", 4'd3, 9'h000);
      sda_m = 1'b1; scl_m = 1'b1;
      quarter();
      rst = 1'b1;
      quarter();
      s0 = strobe_cnt;
      i2c_start();
      send_byte(8'h34, ack); send_byte(8'h0E, ack); send_byte(8'h34, ack);
      i2c_stop();
      check("t5_strobe", strobe_cnt - s0, 1);
      check_reg("t5_reg7", 4'd7, 9'h034);

      // out-of-range register address: ACKed, strobed, not stored
      s0 = strobe_cnt;
      i2c_start();
      send_byte(8'h34, ack); send_byte(8'h40, ack); send_byte(8'hAA, ack);
      check("oor_ack", {31'd0, ack}, 1);
      i2c_stop();
      check("oor_strobe", strobe_cnt - s0, 1);
      check("oor_wr_addr", {25'd0, wr_addr}, 32'h20);
      check("oor_wr_data", {23'd0, wr_data}, 32'h0AA);
      check_reg("oor_reg7", 4'd7, 9'h034);

      // 6: read request
      i2c_start();
      send_byte(8'h34, ack); send_byte(8'h08, ack); send_byte(8'h12, ack);
      i2c_stop();
      s0 = strobe_cnt; e0 = err_cnt;
      i2c_start();
      send_byte(8'h35, ack);
`ifdef I2C_RESP_READ_EN
      check("t6_ack", {31'd0, ack}, 1);
      read_byte(1'b1, rb); check("t6_byte1", {24'd0, rb}, 32'h08);
      read_byte(1'b0, rb); check("t6_byte2", {24'd0, rb}, 32'h12);
`else
      check("t6_nack", {31'd0, ack}, 0);
      read_byte(1'b0, rb); check("t6_released", {24'd0, rb}, 32'hFF);
`endif
      i2c_stop();
      check("t6_strobe", strobe_cnt - s0, 0);
      check("t6_err", err_cnt - e0, 0);
      check("t6_busy", {31'd0, busy}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
